// File: rtl/biquad8_zero_coeff_loader.sv
// biquad8_zero_coeff_loader: replays shadowed b/a coefficients to the zero-FIR port as b, a, update
module biquad8_zero_coeff_loader #(
  parameter int unsigned WR_GAP      = 0,
  parameter              INIT_LOAD   = "TRUE",
  parameter logic [17:0] B_INIT      = 18'h08000,
  parameter logic [17:0] A_INIT      = 18'h04000,
  parameter logic        BYPASS_INIT = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wr_i,
  input  logic [1:0]  addr_i,
  input  logic [17:0] dat_i,
  output logic        busy_o,
  output logic        done_o,
  output logic [17:0] coeff_dat_o,
  output logic        coeff_wr_o,
  output logic        coeff_update_o,
  output logic        bypass_o
);
  localparam logic       L_INIT = (INIT_LOAD == "TRUE");
  localparam logic [3:0] L_GAP  = 4'(WR_GAP);
  typedef enum logic [2:0] {IDLE, WR_B, WAIT_B, WR_A, WAIT_A, UPD} state_t;
  state_t      r_state;
  logic [17:0] r_b, r_a, r_a_snap;
  logic        r_byp, r_byp_snap, r_pend;
  logic [3:0]  r_cnt;
  logic        w_commit, w_start;
  assign w_commit = wr_i && addr_i == 2'd2;
  assign w_start  = r_pend && (r_state == IDLE || r_state == UPD);
  // host-facing shadow registers, writable at any time
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_b   <= B_INIT;
      r_a   <= A_INIT;
      r_byp <= BYPASS_INIT;
    end else if (wr_i) begin
      if (addr_i == 2'd0) r_b <= dat_i;
      if (addr_i == 2'd1) r_a <= dat_i;
      if (addr_i == 2'd2) r_byp <= dat_i[0];
    end
  end
  // load sequencer; outputs are registered alongside each state transition
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state        <= IDLE;
      r_pend         <= L_INIT;
      r_cnt          <= '0;
      r_a_snap       <= A_INIT;
      r_byp_snap     <= BYPASS_INIT;
      coeff_dat_o    <= '0;
      coeff_wr_o     <= 1'b0;
      coeff_update_o <= 1'b0;
      done_o         <= 1'b0;
      busy_o         <= 1'b0;
      bypass_o       <= BYPASS_INIT;
    end else begin
      coeff_wr_o     <= 1'b0;
      coeff_update_o <= 1'b0;
      done_o         <= 1'b0;
      busy_o         <= r_state != IDLE || r_pend;
      if (w_commit) r_pend <= 1'b1;
      case (r_state)
        IDLE: ;
        WR_B, WAIT_B: begin
          if (r_state == WR_B && WR_GAP != 0) begin
            r_state <= WAIT_B;
            r_cnt   <= L_GAP - 4'd1;
          end else if (r_state == WR_B || r_cnt == 4'd0) begin
            r_state     <= WR_A;
            coeff_wr_o  <= 1'b1;
            coeff_dat_o <= r_a_snap;
          end else r_cnt <= r_cnt - 4'd1;
        end
        WR_A, WAIT_A: begin
          if (r_state == WR_A && WR_GAP != 0) begin
            r_state <= WAIT_A;
            r_cnt   <= L_GAP - 4'd1;
          end else if (r_state == WR_A || r_cnt == 4'd0) begin
            r_state        <= UPD;
            coeff_update_o <= 1'b1;
            bypass_o       <= r_byp_snap;
          end else r_cnt <= r_cnt - 4'd1;
        end
        UPD: begin
          done_o  <= 1'b1;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
      if (w_start) begin
        r_state     <= WR_B;
        coeff_wr_o  <= 1'b1;
        coeff_dat_o <= r_b;
        r_a_snap    <= r_a;
        r_byp_snap  <= r_byp;
        r_pend      <= w_commit;
      end
    end
  end
endmodule

// File: tb/tb_biquad8_zero_coeff_loader.sv
// tb_biquad8_zero_coeff_loader: directed cycle-by-cycle checks of the coefficient load sequencer
module tb_biquad8_zero_coeff_loader;
  logic        clk = 0, rst = 1;
  logic        wr_i = 0, wr3 = 0;
  logic [1:0]  addr_i = 0, addr3 = 0;
  logic [17:0] dat_i = 0, dat3 = 0;
  logic        busy_o, done_o, coeff_wr_o, coeff_update_o, bypass_o;
  logic [17:0] coeff_dat_o;
  logic        busy3, done3, wr_o3, upd3, byp3;
  logic [17:0] dat_o3;
  int          tests = 0, fails = 0;
  always #5 clk = ~clk;
  biquad8_zero_coeff_loader dut (
    .clk(clk), .rst(rst), .wr_i(wr_i), .addr_i(addr_i), .dat_i(dat_i),
    .busy_o(busy_o), .done_o(done_o), .coeff_dat_o(coeff_dat_o),
    .coeff_wr_o(coeff_wr_o), .coeff_update_o(coeff_update_o), .bypass_o(bypass_o)
  );
  biquad8_zero_coeff_loader #(.WR_GAP(3)) dut3 (
    .clk(clk), .rst(rst), .wr_i(wr3), .addr_i(addr3), .dat_i(dat3),
    .busy_o(busy3), .done_o(done3), .coeff_dat_o(dat_o3),
    .coeff_wr_o(wr_o3), .coeff_update_o(upd3), .bypass_o(byp3)
  );
  // expected vector layout: {busy, wr, update, done, bypass, dat}
  function automatic logic [22:0] v(input logic b, w, u, d, p, input logic [17:0] x);
    return {b, w, u, d, p, x};
  endfunction
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic hw(input logic [1:0] a, input logic [17:0] d);
    wr_i = 1; addr_i = a; dat_i = d;
    tick();
    wr_i = 0;
  endtask
  task automatic hw3(input logic [1:0] a, input logic [17:0] d);
    wr3 = 1; addr3 = a; dat3 = d;
    tick();
    wr3 = 0;
  endtask
  task automatic test_reset;
    logic [22:0] e [5];
    logic [22:0] o;
    e = '{v(1,1,0,0,1,18'h08000), v(1,1,0,0,1,18'h04000), v(1,0,1,0,1,18'h04000),
          v(1,0,0,1,1,18'h04000), v(0,0,0,0,1,18'h04000)};
    tick(); tick();
    o = {busy_o, coeff_wr_o, coeff_update_o, done_o, bypass_o, coeff_dat_o};
    tests++;
    if (o !== v(0,0,0,0,1,18'h0)) begin
      fails++; $display("FAIL reset_state: got %h want %h", o, v(0,0,0,0,1,18'h0));
    end
    rst = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      o = {busy_o, coeff_wr_o, coeff_update_o, done_o, bypass_o, coeff_dat_o};
      tests++;
      if (o !== e[i]) begin
        fails++; $display("FAIL init_load c%0d: got %h want %h", i + 1, o, e[i]);
      end
    end
  endtask
  task automatic test_commit;
    logic [22:0] e [5];
    logic [22:0] o;
    e = '{v(1,1,0,0,1,18'h3F000), v(1,1,0,0,1,18'h04000), v(1,0,1,0,0,18'h04000),
          v(1,0,0,1,0,18'h04000), v(0,0,0,0,0,18'h04000)};
    hw(0, 18'h3F000); hw(1, 18'h04000); hw(2, 18'h0);
    for (int i = 0; i < 5; i++) begin
      tick();
      o = {busy_o, coeff_wr_o, coeff_update_o, done_o, bypass_o, coeff_dat_o};
      tests++;
      if (o !== e[i]) begin
        fails++; $display("FAIL commit k+%0d: got %h want %h", i + 1, o, e[i]);
      end
    end
  endtask
  task automatic test_back_to_back;
    logic [22:0] e [8];
    logic [22:0] o;
    e = '{v(1,1,0,0,0,18'h3F000), v(1,1,0,0,0,18'h04000), v(1,0,1,0,1,18'h04000),
          v(1,1,0,1,1,18'h00100), v(1,1,0,0,1,18'h04000), v(1,0,1,0,0,18'h04000),
          v(1,0,0,1,0,18'h04000), v(0,0,0,0,0,18'h04000)};
    hw(2, 18'h1);
    for (int i = 0; i < 8; i++) begin
      if (i == 0) hw(0, 18'h00100);
      else if (i < 3) hw(2, 18'h0);
      else tick();
      o = {busy_o, coeff_wr_o, coeff_update_o, done_o, bypass_o, coeff_dat_o};
      tests++;
      if (o !== e[i]) begin
        fails++; $display("FAIL back_to_back k+%0d: got %h want %h", i + 1, o, e[i]);
      end
    end
  endtask
  task automatic test_reset_abort;
    logic [22:0] e [5];
    logic [22:0] o;
    e = '{v(1,1,0,0,1,18'h08000), v(1,1,0,0,1,18'h04000), v(1,0,1,0,1,18'h04000),
          v(1,0,0,1,1,18'h04000), v(0,0,0,0,1,18'h04000)};
    hw(2, 18'h0);
    tick();
    o = {busy_o, coeff_wr_o, coeff_update_o, done_o, bypass_o, coeff_dat_o};
    tests++;
    if (o !== v(1,1,0,0,0,18'h00100)) begin
      fails++; $display("FAIL abort_wr_b: got %h want %h", o, v(1,1,0,0,0,18'h00100));
    end
    tick();
    #2 rst = 1;
    #1;
    for (int i = 0; i < 3; i++) begin
      if (i > 0) tick();
      o = {busy_o, coeff_wr_o, coeff_update_o, done_o, bypass_o, coeff_dat_o};
      tests++;
      if (o !== v(0,0,0,0,1,18'h0)) begin
        fails++; $display("FAIL abort_reset c%0d: got %h want %h", i, o, v(0,0,0,0,1,18'h0));
      end
    end
    tick();
    rst = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      o = {busy_o, coeff_wr_o, coeff_update_o, done_o, bypass_o, coeff_dat_o};
      tests++;
      if (o !== e[i]) begin
        fails++; $display("FAIL abort_reload c%0d: got %h want %h", i + 1, o, e[i]);
      end
    end
  endtask
  task automatic test_ignored;
    logic [22:0] e [5];
    logic [22:0] o;
    e = '{v(1,1,0,0,1,18'h08000), v(1,1,0,0,1,18'h04000), v(1,0,1,0,1,18'h04000),
          v(1,0,0,1,1,18'h04000), v(0,0,0,0,1,18'h04000)};
    hw(3, 18'h3FFFF);
    for (int i = 0; i < 4; i++) begin
      tick();
      o = {busy_o, coeff_wr_o, coeff_update_o, done_o, bypass_o, coeff_dat_o};
      tests++;
      if (o !== v(0,0,0,0,1,18'h04000)) begin
        fails++; $display("FAIL addr3_idle c%0d: got %h want %h", i, o, v(0,0,0,0,1,18'h04000));
      end
    end
    hw(2, 18'h1);
    for (int i = 0; i < 5; i++) begin
      tick();
      o = {busy_o, coeff_wr_o, coeff_update_o, done_o, bypass_o, coeff_dat_o};
      tests++;
      if (o !== e[i]) begin
        fails++; $display("FAIL addr3_shadow k+%0d: got %h want %h", i + 1, o, e[i]);
      end
    end
  endtask
  task automatic test_gap;
    logic [22:0] e [11];
    logic [22:0] o;
    e = '{v(1,1,0,0,1,18'h3F000), v(1,0,0,0,1,18'h3F000), v(1,0,0,0,1,18'h3F000),
          v(1,0,0,0,1,18'h3F000), v(1,1,0,0,1,18'h04000), v(1,0,0,0,1,18'h04000),
          v(1,0,0,0,1,18'h04000), v(1,0,0,0,1,18'h04000), v(1,0,1,0,0,18'h04000),
          v(1,0,0,1,0,18'h04000), v(0,0,0,0,0,18'h04000)};
    for (int i = 0; i < 5; i++) tick();
    hw3(0, 18'h3F000); hw3(1, 18'h04000); hw3(2, 18'h0);
    for (int i = 0; i < 11; i++) begin
      tick();
      o = {busy3, wr_o3, upd3, done3, byp3, dat_o3};
      tests++;
      if (o !== e[i]) begin
        fails++; $display("FAIL gap3 k+%0d: got %h want %h", i + 1, o, e[i]);
      end
    end
  endtask
  initial begin
    test_reset();
    test_commit();
    test_back_to_back();
    test_reset_abort();
    test_ignored();
    test_gap();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
